// File: rtl/fpnew_opgroup_share_arb.sv
// Shares one FPNEW operation-group unit among NumReq requesters: credit-gated round-robin
// issue with {id, tag} tagging and id-based result routing. Define FPNEW_SHARE_ARB_STATS_EN for counters.
module fpnew_opgroup_share_arb #(
  parameter  int unsigned NumReq         = 4,
  parameter  int unsigned ReqWidth       = 128,
  parameter  int unsigned RspWidth       = 38,
  parameter  int unsigned TagWidth       = 8,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned IdWidth        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*ReqWidth-1:0]   req_data_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  output logic                         unit_valid_o,
  input  logic                         unit_ready_i,
  output logic [ReqWidth-1:0]          unit_data_o,
  output logic [IdWidth+TagWidth-1:0]  unit_tag_o,
  output logic                         unit_flush_o,
  input  logic                         unit_valid_i,
  output logic                         unit_ready_o,
  input  logic [RspWidth-1:0]          unit_data_i,
  input  logic [IdWidth+TagWidth-1:0]  unit_tag_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  input  logic [NumReq-1:0]            rsp_ready_i,
  output logic [RspWidth-1:0]          rsp_data_o,
  output logic [TagWidth-1:0]          rsp_tag_o,
`ifdef FPNEW_SHARE_ARB_STATS_EN
  output logic [NumReq*32-1:0]         issue_cnt_o,
  output logic [NumReq*32-1:0]         stall_cnt_o,
`endif
  output logic                         busy_o
);

  localparam int unsigned          CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(MaxOutstanding);
  localparam logic [IdWidth-1:0]   LastId   = IdWidth'(NumReq - 1);

  logic [ReqWidth-1:0] req_data [NumReq];
  logic [TagWidth-1:0] req_tag  [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign req_data[gi] = req_data_i[gi*ReqWidth +: ReqWidth];
    assign req_tag[gi]  = req_tag_i[gi*TagWidth +: TagWidth];
  end

  logic [IdWidth-1:0]  rr_q, rr_d, lock_idx_q, lock_idx_d;
  logic                lock_q, lock_d;
  logic [CntWidth-1:0] cnt_q [NumReq];
  logic [CntWidth-1:0] cnt_d [NumReq];

  logic [NumReq-1:0]   eligible;
  logic [IdWidth-1:0]  rr_grant, grant_idx;
  logic                issue_hs;
  int                  arb_idx;

  // NOTE: every signal driven from always_comb gets a default first, so no latch can be inferred.
  always_comb begin : p_arb
    eligible = '0;
    rr_grant = '0;
    arb_idx  = 0;
    for (int i = 0; i < int'(NumReq); i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < CntMax);
    end
    // Scan from the farthest offset down so the nearest eligible index at/after rr_q wins.
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      arb_idx = (int'(rr_q) + k) % int'(NumReq);
      if (eligible[arb_idx]) rr_grant = IdWidth'(arb_idx);
    end
  end

  assign grant_idx    = lock_q ? lock_idx_q : rr_grant;
  assign unit_valid_o = rst_ni && !flush_i && (lock_q || (|eligible));
  assign issue_hs     = unit_valid_o && unit_ready_i;
  assign unit_data_o  = req_data[grant_idx];
  assign unit_tag_o   = {grant_idx, req_tag[grant_idx]};
  assign unit_flush_o = flush_i;

  always_comb begin : p_req_ready
    req_ready_o = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      req_ready_o[i] = issue_hs && (grant_idx == IdWidth'(i));
    end
  end

  logic [IdWidth-1:0] rsp_id;
  logic               rsp_id_ok, rsp_ready_sel, rsp_hs;

  assign rsp_id     = unit_tag_i[IdWidth+TagWidth-1 -: IdWidth];
  assign rsp_id_ok  = (32'(rsp_id) < NumReq);
  assign rsp_data_o = unit_data_i;
  assign rsp_tag_o  = unit_tag_i[TagWidth-1:0];

  always_comb begin : p_route
    rsp_valid_o   = '0;
    rsp_ready_sel = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      rsp_valid_o[i] = rst_ni && unit_valid_i && (rsp_id == IdWidth'(i));
      if (rsp_id == IdWidth'(i)) rsp_ready_sel = rsp_ready_i[i];
    end
  end

  // Ids with no requester behind them are accepted and dropped.
  assign unit_ready_o = rst_ni && !flush_i && (rsp_id_ok ? rsp_ready_sel : 1'b1);
  assign rsp_hs       = unit_valid_i && unit_ready_o && rsp_id_ok;

  always_comb begin : p_next
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    for (int i = 0; i < int'(NumReq); i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i) begin
        cnt_d[i] = '0;
      end else if (issue_hs && (grant_idx == IdWidth'(i)) &&
                   !(rsp_hs && (rsp_id == IdWidth'(i)))) begin
        if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rsp_hs && (rsp_id == IdWidth'(i)) &&
                   !(issue_hs && (grant_idx == IdWidth'(i)))) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    if (flush_i) begin
      lock_d = 1'b0;
    end else if (issue_hs) begin
      lock_d = 1'b0;
      rr_d   = (grant_idx == LastId) ? '0 : grant_idx + 1'b1;
    end else if (unit_valid_o) begin
      // Stalled offer: pin the selection so valid and payload stay stable.
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end
  end

  // NOTE: state registers take non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < int'(NumReq); i++) cnt_q[i] <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int i = 0; i < int'(NumReq); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic cnt_nz;
  always_comb begin : p_busy
    cnt_nz = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) cnt_nz = cnt_nz || (cnt_q[i] != '0);
  end
  assign busy_o = cnt_nz || unit_valid_o;

`ifdef FPNEW_SHARE_ARB_STATS_EN
  logic [31:0] issue_cnt_q [NumReq];
  logic [31:0] stall_cnt_q [NumReq];

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumReq); i++) begin
        issue_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NumReq); i++) begin
        if (req_ready_o[i]) issue_cnt_q[i] <= issue_cnt_q[i] + 32'd1;
        if (req_valid_i[i] && !req_ready_o[i] && (stall_cnt_q[i] != '1))
          stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_stats
    assign issue_cnt_o[gi*32 +: 32] = issue_cnt_q[gi];
    assign stall_cnt_o[gi*32 +: 32] = stall_cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_fpnew_opgroup_share_arb.sv
// Bench for fpnew_opgroup_share_arb: vector table, directed corner sequences, and a
// randomized run against a count-based reference model.
module tb_fpnew_opgroup_share_arb;

  localparam int N  = 4;
  localparam int RW = 16;
  localparam int SW = 8;
  localparam int TW = 8;
  localparam int MO = 2;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N*RW-1:0]   req_data_i = '0;
  logic [N*TW-1:0]   req_tag_i = '0;
  logic              unit_valid_o;
  logic              unit_ready_i = 1'b0;
  logic [RW-1:0]     unit_data_o;
  logic [IW+TW-1:0]  unit_tag_o;
  logic              unit_flush_o;
  logic              unit_valid_i = 1'b0;
  logic              unit_ready_o;
  logic [SW-1:0]     unit_data_i = 8'h5A;
  logic [IW+TW-1:0]  unit_tag_i = '0;
  logic [N-1:0]      rsp_valid_o;
  logic [N-1:0]      rsp_ready_i = '0;
  logic [SW-1:0]     rsp_data_o;
  logic [TW-1:0]     rsp_tag_o;
  logic              busy_o;
`ifdef FPNEW_SHARE_ARB_STATS_EN
  logic [N*32-1:0]   issue_cnt_o;
  logic [N*32-1:0]   stall_cnt_o;
`endif

  always #5 clk = ~clk;

  fpnew_opgroup_share_arb #(
    .NumReq(N), .ReqWidth(RW), .RspWidth(SW), .TagWidth(TW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .req_tag_i(req_tag_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
    .unit_data_o(unit_data_o), .unit_tag_o(unit_tag_o), .unit_flush_o(unit_flush_o),
    .unit_valid_i(unit_valid_i), .unit_ready_o(unit_ready_o),
    .unit_data_i(unit_data_i), .unit_tag_i(unit_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o),
`ifdef FPNEW_SHARE_ARB_STATS_EN
    .issue_cnt_o(issue_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .busy_o(busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rv, input logic ur, input logic uvi,
                       input logic [9:0] utag, input logic [3:0] rrdy, input logic fl);
    req_valid_i  = rv;
    unit_ready_i = ur;
    unit_valid_i = uvi;
    unit_tag_i   = utag;
    rsp_ready_i  = rrdy;
    flush_i      = fl;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic cyc(input logic [3:0] rv, input logic ur, input logic uvi,
                     input logic [9:0] utag, input logic [3:0] rrdy, input logic fl);
    @(negedge clk);
    drive(rv, ur, uvi, utag, rrdy, fl);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(4'h0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0);
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  task automatic fixed_payload();
    for (int i = 0; i < N; i++) begin
      req_data_i[i*RW +: RW] = 16'hD000 + 16'(i);
      req_tag_i[i*TW +: TW]  = 8'h40 + 8'(i);
    end
  endtask

  typedef struct {
    logic [3:0] rv;   logic ur;  logic uvi; logic [9:0] utag; logic [3:0] rrdy; logic fl;
    logic       euv;  logic [3:0] erdy; logic [1:0] egid; logic eurdy; logic [3:0] ersv; logic ebusy;
  } vec_t;

  vec_t tbl [10];

  // Random-phase model state: outstanding count per requester, next-priority index, held grant.
  int         m_cnt [N];
  int         m_delta [N];
  int         m_rr, m_lock, g, id;
  logic [3:0] rv, rrdy, erdy, ersv;
  logic       ur, uvi, fl, ev, eurdy, ebusy;
  logic [7:0] tl;
  logic [9:0] etag;
  logic [15:0] edata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rv    ur uvi utag    rrdy  fl   euv erdy     gid   urdy rspv     busy
    tbl[0] = '{4'hF, 1, 0, 10'h000, 4'hF, 0,  1, 4'b0001, 2'd0, 1, 4'b0000, 1};
    tbl[1] = '{4'hF, 1, 0, 10'h000, 4'hF, 0,  1, 4'b0010, 2'd1, 1, 4'b0000, 1};
    tbl[2] = '{4'hF, 1, 0, 10'h000, 4'hF, 0,  1, 4'b0100, 2'd2, 1, 4'b0000, 1};
    tbl[3] = '{4'hF, 1, 0, 10'h000, 4'hF, 0,  1, 4'b1000, 2'd3, 1, 4'b0000, 1};
    tbl[4] = '{4'hF, 1, 0, 10'h000, 4'hF, 0,  1, 4'b0001, 2'd0, 1, 4'b0000, 1};
    tbl[5] = '{4'h0, 1, 1, 10'h2A5, 4'h0, 0,  0, 4'b0000, 2'd0, 0, 4'b0100, 1};
    tbl[6] = '{4'h0, 1, 1, 10'h2A5, 4'h4, 0,  0, 4'b0000, 2'd0, 1, 4'b0100, 1};
    tbl[7] = '{4'h4, 1, 0, 10'h000, 4'h0, 0,  1, 4'b0100, 2'd2, 0, 4'b0000, 1};
    tbl[8] = '{4'h4, 1, 0, 10'h000, 4'h0, 0,  1, 4'b0100, 2'd2, 0, 4'b0000, 1};
    tbl[9] = '{4'h4, 1, 0, 10'h000, 4'h0, 0,  0, 4'b0000, 2'd0, 0, 4'b0000, 1};

    fixed_payload();
    drive(4'hF, 1'b1, 1'b1, 10'h1AA, 4'hF, 1'b0);
    #1;
    check("reset_unit_valid", unit_valid_o, 0);
    check("reset_req_ready", req_ready_o, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_busy", busy_o, 0);
    do_reset();

    // Fairness, response routing and credit return.
    for (int r = 0; r < 10; r++) begin
      cyc(tbl[r].rv, tbl[r].ur, tbl[r].uvi, tbl[r].utag, tbl[r].rrdy, tbl[r].fl);
      check($sformatf("vec%0d_unit_valid", r), unit_valid_o, tbl[r].euv);
      check($sformatf("vec%0d_req_ready", r), req_ready_o, tbl[r].erdy);
      if (tbl[r].euv) begin
        check($sformatf("vec%0d_unit_tag", r), unit_tag_o, {tbl[r].egid, 8'h40 + 8'(tbl[r].egid)});
        check($sformatf("vec%0d_unit_data", r), unit_data_o, 16'hD000 + 16'(tbl[r].egid));
      end
      check($sformatf("vec%0d_unit_ready", r), unit_ready_o, tbl[r].eurdy);
      check($sformatf("vec%0d_rsp_valid", r), rsp_valid_o, tbl[r].ersv);
      check($sformatf("vec%0d_rsp_tag", r), rsp_tag_o, tbl[r].utag[7:0]);
      check($sformatf("vec%0d_rsp_data", r), rsp_data_o, 8'h5A);
      check($sformatf("vec%0d_busy", r), busy_o, tbl[r].ebusy);
    end

    // Backpressure lock.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(4'b0101, 0, 0, 10'h000, 4'hF, 0);
      check("lock_hold_valid", unit_valid_o, 1);
      check("lock_hold_tag", unit_tag_o, {2'd0, 8'h40});
      check("lock_hold_data", unit_data_o, 16'hD000);
      check("lock_hold_ready", req_ready_o, 0);
    end
    cyc(4'b0111, 0, 0, 10'h000, 4'hF, 0);
    check("lock_late_req1_tag", unit_tag_o, {2'd0, 8'h40});
    cyc(4'b0111, 1, 0, 10'h000, 4'hF, 0);
    check("lock_release_ready", req_ready_o, 4'b0001);
    cyc(4'b0110, 1, 0, 10'h000, 4'hF, 0);
    check("lock_next_grant", req_ready_o, 4'b0010);
    check("lock_next_tag", unit_tag_o, {2'd1, 8'h41});
    cyc(4'b1000, 0, 0, 10'h000, 4'hF, 0);
    check("lock3_tag", unit_tag_o, {2'd3, 8'h43});
    cyc(4'b1100, 0, 0, 10'h000, 4'hF, 0);
    check("lock3_hold_over_rr", unit_tag_o, {2'd3, 8'h43});
    check("lock3_hold_data", unit_data_o, 16'hD003);
    cyc(4'b1100, 1, 0, 10'h000, 4'hF, 0);
    check("lock3_release", req_ready_o, 4'b1000);

    // Credits.
    do_reset();
    cyc(4'b0010, 1, 0, 10'h000, 4'hF, 0);
    check("credit_issue1", req_ready_o, 4'b0010);
    cyc(4'b0010, 1, 0, 10'h000, 4'hF, 0);
    check("credit_issue2", req_ready_o, 4'b0010);
    cyc(4'b0010, 1, 0, 10'h000, 4'hF, 0);
    check("credit_full_valid", unit_valid_o, 0);
    check("credit_full_ready", req_ready_o, 0);
    check("credit_full_busy", busy_o, 1);
    cyc(4'b0010, 1, 1, 10'h133, 4'hF, 0);
    check("credit_rsp_valid", rsp_valid_o, 4'b0010);
    check("credit_rsp_ready", unit_ready_o, 1);
    check("credit_rsp_same_cycle", unit_valid_o, 0);
    cyc(4'b0010, 1, 0, 10'h000, 4'hF, 0);
    check("credit_returned", req_ready_o, 4'b0010);

    // Simultaneous issue and response on requester 3.
    do_reset();
    cyc(4'b1000, 1, 0, 10'h000, 4'hF, 0);
    check("simul_first", req_ready_o, 4'b1000);
    cyc(4'b1000, 1, 1, 10'h377, 4'hF, 0);
    check("simul_issue", req_ready_o, 4'b1000);
    check("simul_rsp_ready", unit_ready_o, 1);
    check("simul_rsp_valid", rsp_valid_o, 4'b1000);
    cyc(4'b0000, 0, 0, 10'h000, 4'hF, 0);
    check("simul_busy", busy_o, 1);
    cyc(4'b1000, 1, 0, 10'h000, 4'hF, 0);
    check("simul_cnt_was_1", req_ready_o, 4'b1000);
    cyc(4'b1000, 1, 0, 10'h000, 4'hF, 0);
    check("simul_now_full", unit_valid_o, 0);

    // Flush.
    do_reset();
    cyc(4'b0111, 1, 0, 10'h000, 4'hF, 0);
    check("flush_pre0", req_ready_o, 4'b0001);
    cyc(4'b0111, 1, 0, 10'h000, 4'hF, 0);
    check("flush_pre1", req_ready_o, 4'b0010);
    cyc(4'b0111, 1, 0, 10'h000, 4'hF, 0);
    check("flush_pre2", req_ready_o, 4'b0100);
    cyc(4'b0111, 1, 1, 10'h000, 4'hF, 1);
    check("flush_fwd", unit_flush_o, 1);
    check("flush_unit_valid", unit_valid_o, 0);
    check("flush_req_ready", req_ready_o, 0);
    check("flush_unit_ready", unit_ready_o, 0);
    cyc(4'b0000, 0, 0, 10'h000, 4'hF, 0);
    check("flush_busy_after", busy_o, 0);
    check("flush_fwd_low", unit_flush_o, 0);
    cyc(4'b1001, 1, 0, 10'h000, 4'hF, 0);
    check("flush_rr_kept", req_ready_o, 4'b1000);

    // Reset in the middle of an issue.
    cyc(4'hF, 1, 0, 10'h000, 4'hF, 0);
    check("midrst_pre_valid", unit_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_unit_valid", unit_valid_o, 0);
    check("midrst_req_ready", req_ready_o, 0);
    check("midrst_busy", busy_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_rr   = 0;
    m_lock = -1;
    for (int cy = 0; cy < 1500; cy++) begin
      @(negedge clk);
      rv = 4'($urandom);
      if (m_lock >= 0) rv[m_lock] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (i != m_lock) begin
          req_data_i[i*RW +: RW] = 16'($urandom);
          req_tag_i[i*TW +: TW]  = 8'($urandom);
        end
      end
      ur   = ($urandom_range(0, 3) != 0);
      uvi  = 1'($urandom_range(0, 1));
      id   = $urandom_range(0, N - 1);
      tl   = 8'($urandom);
      rrdy = 4'($urandom);
      fl   = ($urandom_range(0, 49) == 0);
      unit_data_i = 8'($urandom);
      drive(rv, ur, uvi, {2'(id), tl}, rrdy, fl);
      #1;

      g = -1;
      if (m_lock >= 0) g = m_lock;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && rv[(m_rr + k) % N] && m_cnt[(m_rr + k) % N] < MO) g = (m_rr + k) % N;
      ev    = (g >= 0) && !fl;
      erdy  = (ev && ur) ? 4'(1 << g) : 4'h0;
      etag  = ev ? {2'(g), req_tag_i[g*TW +: TW]} : 10'h0;
      edata = ev ? req_data_i[g*RW +: RW] : 16'h0;
      ersv  = uvi ? 4'(1 << id) : 4'h0;
      eurdy = !fl && rrdy[id];
      ebusy = ev;
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) ebusy = 1'b1;

      check($sformatf("rnd%0d_issue", cy),
            {unit_valid_o, req_ready_o, unit_valid_o ? unit_tag_o : 10'h0, unit_valid_o ? unit_data_o : 16'h0},
            {ev, erdy, etag, edata});
      check($sformatf("rnd%0d_rsp", cy),
            {rsp_valid_o, unit_ready_o, rsp_tag_o, rsp_data_o, unit_flush_o},
            {ersv, eurdy, tl, unit_data_i, fl});
      check($sformatf("rnd%0d_busy", cy), busy_o, ebusy);

      if (fl) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_lock = -1;
      end else begin
        for (int i = 0; i < N; i++) m_delta[i] = 0;
        if (ev && ur) m_delta[g]++;
        if (uvi && eurdy) m_delta[id]--;
        for (int i = 0; i < N; i++) begin
          m_cnt[i] = m_cnt[i] + m_delta[i];
          if (m_cnt[i] < 0)  m_cnt[i] = 0;
          if (m_cnt[i] > MO) m_cnt[i] = MO;
        end
        if (ev && ur) begin
          m_rr   = (g + 1) % N;
          m_lock = -1;
        end else if (ev) begin
          m_lock = g;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpnew_opgroup_share_arb.md
Name: fpnew_opgroup_share_arb

Overview:
- Shares one FPU operation-group block between NumReq independent requesters, e.g. several cores or lanes.
- Issue side: round-robin arbitration, gated by per-requester outstanding-operation credits.
- Each issued tag gets the requester ID appended; the unit's results are routed back to the owning requester using that ID.
- Sits between requester issue ports and the shared unit's input/output handshakes.

Parameters:
- NumReq, 4, number of requesters (>=2).
- ReqWidth, 128, width of opaque request payload (operands, op, fmt fields) forwarded unchanged.
- RspWidth, 38, width of opaque result payload (result, status, ext bit) returned unchanged.
- TagWidth, 8, requester-side tag width.
- MaxOutstanding, 4, max in-flight ops per requester (>=1).
- IdWidth (derived), max(1, clog2(NumReq)).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  drop all in-flight ops.
- req_valid_i  in  NumReq  request valid per requester.
- req_ready_o  out  NumReq  request accepted.
- req_data_i  in  NumReq x ReqWidth  request payloads.
- req_tag_i  in  NumReq x TagWidth  request tags.
- unit_valid_o  out  1  issue valid to shared unit.
- unit_ready_i  in  1  shared unit ready.
- unit_data_o  out  ReqWidth  selected payload.
- unit_tag_o  out  IdWidth+TagWidth  {id, tag}.
- unit_flush_o  out  1  flush_i forwarded combinationally.
- unit_valid_i  in  1  result valid from unit.
- unit_ready_o  out  1  result accepted.
- unit_data_i  in  RspWidth  result payload.
- unit_tag_i  in  IdWidth+TagWidth  returned {id, tag}.
- rsp_valid_o  out  NumReq  per-requester result valid.
- rsp_ready_i  in  NumReq  per-requester result ready.
- rsp_data_o  out  RspWidth  result payload, shared bus.
- rsp_tag_o  out  TagWidth  original tag, id stripped.
- busy_o  out  1  any outstanding count non-zero, or unit_valid_o.

Behaviour:
- Reset: rr pointer=0, all outstanding counters=0, lock=0.
  - Outputs in reset: unit_valid_o=0, req_ready_o=0, rsp_valid_o=0, busy_o=0.
- Eligibility: eligible[i] = req_valid_i[i] & (cnt[i] < MaxOutstanding).
- Arbitration:
  - Grant the first eligible index at or after the rr pointer, wrapping NumReq-1 -> 0.
  - unit_valid_o = |eligible, or lock.
  - Data/tag are muxed combinationally, zero issue latency.
- Lock:
  - If unit_valid_o=1 and unit_ready_i=0, register the granted index and lock=1.
  - While locked, the selection is held regardless of other requesters. This keeps valid and payload stable (AXI rule).
  - Requester i must keep its request asserted once it is granted.
  - lock clears on handshake.
- Issue handshake (unit_valid_o & unit_ready_i):
  - req_ready_o[g]=1 for the granted g only; all other bits are 0.
  - cnt[g]++ and the rr pointer becomes (g+1) mod NumReq.
  - req_ready_o[i] never depends on req_valid_i of other requesters except through arbitration.
- Response routing:
  - id = unit_tag_i[IdWidth+TagWidth-1 -: IdWidth].
  - rsp_valid_o[id] = unit_valid_i; all other bits are 0.
  - unit_ready_o = rsp_ready_i[id].
  - rsp_tag_o = low TagWidth bits of unit_tag_i.
  - Purely combinational, zero latency, no buffering.
  - An id >= NumReq gives unit_ready_o=1 (drop) and no rsp_valid_o.
- Counter update: on a response handshake, cnt[id]--.
  - Issue and response for the same requester in the same cycle: counter unchanged.
  - Counters saturate at 0 (a response with cnt=0 does not underflow) and at MaxOutstanding.
- Flush:
  - In the flush cycle, all counters->0 and lock->0; rr pointer unchanged.
  - unit_valid_o and unit_ready_o are forced to 0.
- Reset mid-operation: state is cleared asynchronously; the outstanding ops are abandoned.
- busy_o = (|cnt != 0) | unit_valid_o.

Optional Feature:
- Macro: FPNEW_SHARE_ARB_STATS_EN.
- When defined:
  - Adds output issue_cnt_o (NumReq x 32), counting issue handshakes per requester; it wraps at 2^32 and is reset to 0.
  - Adds output stall_cnt_o (NumReq x 32), counting cycles where req_valid_i[i]=1 and req_ready_o[i]=0; it saturates at 2^32-1.
  - Neither counter is cleared by flush.
- When undefined: the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Fairness: NumReq=4, all 4 valid, unit_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles; unit_tag_o id field matches each grant.
- Backpressure lock: req0 and req2 valid, unit_ready_i=0 for 3 cycles, then req1 raises valid -> grant stays 0 with stable data; the next grant after the handshake is 1.
- Credits: MaxOutstanding=2, req1 issues 2 ops, no responses -> req1 is ineligible and req_ready_o[1]=0. One response with id=1 -> req1 eligible the next cycle.
- Simultaneous: cnt[3]=1, issue and response for id 3 in the same cycle -> cnt[3]=1 afterwards, busy_o=1.
- Routing: unit_tag_i={2'd2, 8'hA5}, rsp_ready_i=4'b0000 -> rsp_valid_o=4'b0100, unit_ready_o=0, rsp_tag_o=8'hA5. Set rsp_ready_i[2]=1 -> handshake and cnt[2] decrements.
- Flush/reset: 3 ops outstanding, pulse flush_i -> unit_flush_o=1 that cycle, all counters=0, busy_o=0 the next cycle. Assert rst_ni=0 mid-issue -> unit_valid_o=0 immediately.
